// File: rtl/firing_pkg.sv
// rtl/firing_pkg.sv - control codes and sequencer state encoding for the firing datapath
package firing_pkg;

    localparam logic [2:0] CTRL_RELOAD = 3'b000;
    localparam logic [2:0] CTRL_HOLD   = 3'b001;
    localparam logic [2:0] CTRL_SHOT   = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        SHOOT,
        COOLDOWN,
        EMPTY,
        RELOAD
    } fire_state_t;

endpackage

// File: rtl/firing_control_if.sv
// rtl/firing_control_if.sv - round-logic/datapath side signals of the firing sequencer
interface firing_control_if;

    logic       reload_req;
    logic       round_active;
    logic [1:0] remaining_shots;
    logic [2:0] control;
    logic       shot_fired;
    logic       busy;
    logic       empty;

    modport master (
        input  reload_req,
        input  round_active,
        input  remaining_shots,
        output control,
        output shot_fired,
        output busy,
        output empty
    );

    modport slave (
        output reload_req,
        output round_active,
        output remaining_shots,
        input  control,
        input  shot_fired,
        input  busy,
        input  empty
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchronizer plus debounce counter for an active-low key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    // level follows sync1 only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
            level <= 1'b1;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync0 <= key_n;
            sync1 <= sync0;
            press <= 1'b0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                level <= sync1;
                press <= level & ~sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/firing_control.sv
// rtl/firing_control.sv - trigger-to-SHOT sequencer with cooldown, empty lockout and timed reload
module firing_control
    import firing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int COOLDOWN_CYCLES = 12_500_000,
    parameter int RELOAD_CYCLES   = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                trigger_n,
    firing_control_if.master    bus
);

    localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [CNT_W-1:0] RLD_LOAD = CNT_W'(RELOAD_CYCLES);

    fire_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_level;
    logic             key_press;
    logic             press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trigger (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (trigger_n),
        .level   (key_level),
        .press   (key_press)
    );

    assign press = key_press & ~key_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bus.control    <= CTRL_HOLD;
            bus.shot_fired <= 1'b0;
            bus.busy       <= 1'b0;
            bus.empty      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus.control    <= (state_d == SHOOT)  ? CTRL_SHOT :
                              (state_d == RELOAD) ? CTRL_RELOAD : CTRL_HOLD;
            bus.shot_fired <= (state_d == SHOOT);
            bus.busy       <= (state_d == COOLDOWN) || (state_d == RELOAD);
            bus.empty      <= (state_d == EMPTY);
        end
    end

    // One counter serves both timed phases; it only counts down while nonzero
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        case (state_q)
            IDLE: begin
                if (bus.reload_req) begin
                    state_d = RELOAD;
                    cnt_d   = RLD_LOAD;
                end else if (press && bus.round_active) begin
                    state_d = (bus.remaining_shots != 2'd0) ? SHOOT : EMPTY;
                end
            end
            SHOOT: begin
                if (bus.reload_req) begin
                    state_d = RELOAD;
                    cnt_d   = RLD_LOAD;
                end else begin
                    state_d = COOLDOWN;
                    cnt_d   = CD_LOAD;
                end
            end
            COOLDOWN: begin
                if (bus.reload_req) begin
                    state_d = RELOAD;
                    cnt_d   = RLD_LOAD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = (bus.remaining_shots == 2'd0) ? EMPTY : IDLE;
                end
            end
            EMPTY: begin
                if (bus.reload_req) begin
                    state_d = RELOAD;
                    cnt_d   = RLD_LOAD;
                end
            end
            RELOAD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
